biriscv_fetch_unit: RTL and testbench

BIRISCV_FETCH_UNIT -- requirements
Module: biriscv_fetch_unit

---
 rtl/biriscv_fetch_unit.sv | 129 ++++++++++++
 tb/tb_biriscv_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_fetch_unit.sv
// rtl/biriscv_fetch_unit.sv - instruction fetch unit: icache request sequencing, skid buffer, redirect handling
module biriscv_fetch_unit #(
  parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [1:0]  branch_priv_i,
  input  logic        fetch_accept_i,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  input  logic [63:0] icache_inst_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o
);

  logic [31:3] pc_q;
  logic [1:0]  priv_q;
  logic        outstanding_q;
  logic        drop_q;
  logic        halt_q;
  logic [31:3] req_pc_q;

  logic        skid_valid_q;
  logic [63:0] skid_data_q;
  logic [31:3] skid_pc_q;
  logic        skid_err_q;
  logic        skid_pf_q;

  logic        resp_w;
  logic        resp_fault_w;
  logic        rd_w;
  logic        req_accept_w;
  logic        unused_w;

  // Only the 8-byte aligned part of the redirect target is used.
  assign unused_w = ^branch_pc_i[2:0];

  // A response is live only if we asked for it and it was not cancelled by a redirect.
  assign resp_w       = outstanding_q & icache_valid_i & ~drop_q;
  assign resp_fault_w = resp_w & (icache_error_i | icache_page_fault_i);

  // One request in flight; a new one may overlap the cycle its predecessor returns
  // and is consumed. Nothing past a faulting bundle is requested.
  assign rd_w = ~branch_request_i & ~halt_q & ~skid_valid_q & ~resp_fault_w &
                (~outstanding_q | (icache_valid_i & (drop_q | fetch_accept_i)));
  assign req_accept_w = rd_w & icache_accept_i;

  assign icache_rd_o   = rd_w;
  assign icache_pc_o   = {pc_q, 3'b000};
  assign icache_priv_o = priv_q;

  // Skid contents take precedence; otherwise the icache response goes straight to decode.
  assign fetch_valid_o       = ~branch_request_i & (skid_valid_q | resp_w);
  assign fetch_instr_o       = skid_valid_q ? skid_data_q : icache_inst_i;
  assign fetch_pc_o          = {(skid_valid_q ? skid_pc_q : req_pc_q), 3'b000};
  assign fetch_fault_fetch_o = skid_valid_q ? skid_err_q : icache_error_i;
  assign fetch_fault_page_o  = skid_valid_q ? skid_pf_q  : icache_page_fault_i;
  assign fetch_pred_branch_o = 2'b00;

  // Fetch pointer and privilege: redirect wins, otherwise advance on an accepted request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q     <= BOOT_VECTOR[31:3];
      priv_q   <= 2'b11;
      req_pc_q <= '0;
    end else if (branch_request_i) begin
      pc_q   <= branch_pc_i[31:3];
      priv_q <= branch_priv_i;
    end else if (req_accept_w) begin
      pc_q     <= pc_q + 29'd1;
      req_pc_q <= pc_q;
    end
  end

  // In-flight tracking, stale-response dropping and halt-after-fault.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      if (req_accept_w)
        outstanding_q <= 1'b1;
      else if (icache_valid_i)
        outstanding_q <= 1'b0;

      if (branch_request_i)
        drop_q <= outstanding_q & ~icache_valid_i;
      else if (outstanding_q & icache_valid_i)
        drop_q <= 1'b0;

      if (branch_request_i)
        halt_q <= 1'b0;
      else if (resp_fault_w)
        halt_q <= 1'b1;
    end
  end

  // Skid buffer catches a response decode could not take this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      skid_err_q   <= 1'b0;
      skid_pf_q    <= 1'b0;
    end else if (branch_request_i || fetch_accept_i) begin
      skid_valid_q <= 1'b0;
    end else if (resp_w && !skid_valid_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= icache_inst_i;
      skid_pc_q    <= req_pc_q;
      skid_err_q   <= icache_error_i;
      skid_pf_q    <= icache_page_fault_i;
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_unit.sv
// tb/tb_biriscv_fetch_unit.sv - directed table-driven bench for biriscv_fetch_unit
module tb_biriscv_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        branch_request_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic [1:0]  branch_priv_i = '0;
  logic        fetch_accept_i = 1'b1;
  logic        icache_accept_i = 1'b1;
  logic        icache_valid_i = 1'b0;
  logic        icache_error_i = 1'b0;
  logic        icache_page_fault_i = 1'b0;
  logic [63:0] icache_inst_i = '0;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;

  biriscv_fetch_unit #(.BOOT_VECTOR(32'h80000000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i), .branch_priv_i(branch_priv_i),
    .fetch_accept_i(fetch_accept_i), .icache_accept_i(icache_accept_i),
    .icache_valid_i(icache_valid_i), .icache_error_i(icache_error_i),
    .icache_page_fault_i(icache_page_fault_i), .icache_inst_i(icache_inst_i),
    .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .fetch_fault_fetch_o(fetch_fault_fetch_o), .fetch_fault_page_o(fetch_fault_page_o),
    .fetch_pred_branch_o(fetch_pred_branch_o),
    .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .icache_priv_o(icache_priv_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, br;
    logic [31:0] bpc;
    logic [1:0]  bpriv;
    logic        facc, ival, ierr, ipf;
    logic [63:0] inst;
    logic        chk_rd, e_rd, chk_pc;
    logic [31:0] e_ipc;
    logic [1:0]  e_priv;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [63:0] e_instr;
    logic        e_ferr, e_fpf;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];

  localparam logic [63:0] D1 = 64'h0000_0013_0010_0093;
  localparam logic [63:0] D2 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D3 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D5 = 64'h5A5A_A5A5_0F0F_F0F0;
  localparam logic [63:0] D6 = 64'h6666_0000_6666_0001;
  localparam logic [63:0] D7 = 64'h7777_7777_7777_7777;
  localparam logic [63:0] D8 = 64'h8888_0001_8888_0002;
  localparam logic [63:0] D9 = 64'h9999_9999_0000_0009;
  localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C;

  function automatic vec_t v(logic rst, logic br, logic [31:0] bpc, logic [1:0] bpriv, logic facc,
                             logic ival, logic ierr, logic ipf, logic [63:0] inst,
                             logic chk_rd, logic e_rd, logic chk_pc, logic [31:0] e_ipc, logic [1:0] e_priv,
                             logic e_fv, logic [31:0] e_fpc, logic [63:0] e_instr, logic e_ferr, logic e_fpf);
    vec_t r;
    r.rst = rst; r.br = br; r.bpc = bpc; r.bpriv = bpriv; r.facc = facc;
    r.ival = ival; r.ierr = ierr; r.ipf = ipf; r.inst = inst;
    r.chk_rd = chk_rd; r.e_rd = e_rd; r.chk_pc = chk_pc; r.e_ipc = e_ipc; r.e_priv = e_priv;
    r.e_fv = e_fv; r.e_fpc = e_fpc; r.e_instr = e_instr; r.e_ferr = e_ferr; r.e_fpf = e_fpf;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst_i = t.rst; branch_request_i = t.br; branch_pc_i = t.bpc; branch_priv_i = t.bpriv;
    fetch_accept_i = t.facc; icache_accept_i = 1'b1; icache_valid_i = t.ival;
    icache_error_i = t.ierr; icache_page_fault_i = t.ipf; icache_inst_i = t.inst;
  endtask

  initial begin
    // rst br bpc bpriv facc ival err pf inst | chk_rd e_rd chk_pc e_ipc e_priv | e_fv e_fpc e_instr e_ferr e_fpf
    tbl.push_back(v(1,0,0,0,1, 0,0,0,0,  0,0,1,32'h80000000,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,1,1,32'h80000000,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h80000008,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,D1, 1,1,1,32'h80000008,3, 1,32'h80000000,D1,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h80000010,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,D2, 1,1,1,32'h80000010,3, 1,32'h80000008,D2,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h80000018,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,D3, 1,0,1,32'h80000018,3, 1,32'h80000010,D3,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,  1,0,1,32'h80000018,3, 1,32'h80000010,D3,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,0,0,  1,0,1,32'h80000018,3, 1,32'h80000010,D3,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h80000018,3, 1,32'h80000010,D3,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,1,1,32'h80000018,3, 0,0,0,0,0));
    tbl.push_back(v(0,1,32'h00001004,1,1, 0,0,0,0, 1,0,1,32'h80000020,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00001000,1, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,D4, 1,1,1,32'h00001000,1, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00001008,1, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,1,D5, 1,0,1,32'h00001008,1, 1,32'h00001000,D5,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00001008,1, 1,32'h00001000,D5,0,1));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00001008,1, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00001008,1, 0,0,0,0,0));
    tbl.push_back(v(0,1,32'h00002000,3,1, 0,0,0,0, 1,0,1,32'h00001008,1, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,1,1,32'h00002000,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,D6, 1,1,1,32'h00002008,3, 1,32'h00002000,D6,0,0));
    tbl.push_back(v(0,1,32'hFFFFFFF8,3,1, 1,0,0,D7, 1,0,1,32'h00002010,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,1,1,32'hFFFFFFF8,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,D8, 1,1,1,32'h00000000,3, 1,32'hFFFFFFF8,D8,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,1,32'h00000008,3, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,1,0,D9, 0,0,0,0,3,            1,32'h00000000,D9,1,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,0,0,3,            0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,0,0,  1,0,0,0,3,            0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk_i); #1;
      drive(tbl[i]);
      @(negedge clk_i);
      chk($sformatf("c%0d fetch_valid", i), 64'(fetch_valid_o), 64'(tbl[i].e_fv));
      chk($sformatf("c%0d pred_branch", i), 64'(fetch_pred_branch_o), 64'd0);
      if (tbl[i].chk_rd)
        chk($sformatf("c%0d icache_rd", i), 64'(icache_rd_o), 64'(tbl[i].e_rd));
      if (tbl[i].chk_pc) begin
        chk($sformatf("c%0d icache_pc", i), 64'(icache_pc_o), 64'(tbl[i].e_ipc));
        chk($sformatf("c%0d icache_priv", i), 64'(icache_priv_o), 64'(tbl[i].e_priv));
      end
      if (tbl[i].e_fv) begin
        chk($sformatf("c%0d fetch_pc", i), 64'(fetch_pc_o), 64'(tbl[i].e_fpc));
        chk($sformatf("c%0d fetch_instr", i), fetch_instr_o, tbl[i].e_instr);
        chk($sformatf("c%0d fault_fetch", i), 64'(fetch_fault_fetch_o), 64'(tbl[i].e_ferr));
        chk($sformatf("c%0d fault_page", i), 64'(fetch_fault_page_o), 64'(tbl[i].e_fpf));
      end
    end

    // Redirect out of halt, then fill the skid and reset asynchronously.
    @(posedge clk_i); #1;
    branch_request_i = 1'b1; branch_pc_i = 32'h00003000; branch_priv_i = 2'b11;
    icache_valid_i = 1'b0; icache_error_i = 1'b0; fetch_accept_i = 1'b1;
    @(posedge clk_i); #1;
    branch_request_i = 1'b0;
    @(negedge clk_i);
    chk("h_req_3000_rd", 64'(icache_rd_o), 64'd1);
    chk("h_req_3000_pc", 64'(icache_pc_o), 64'h00003000);
    @(posedge clk_i); #1;
    icache_valid_i = 1'b1; icache_inst_i = DA; fetch_accept_i = 1'b0;
    @(negedge clk_i);
    chk("h_resp_3000_pc", 64'(fetch_pc_o), 64'h00003000);
    @(posedge clk_i); #1;
    icache_valid_i = 1'b0;
    @(negedge clk_i);
    chk("h_skid_valid", 64'(fetch_valid_o), 64'd1);
    chk("h_skid_instr", fetch_instr_o, DA);
    #2 rst_i = 1'b1;
    #1 chk("h_async_rst_valid", 64'(fetch_valid_o), 64'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; fetch_accept_i = 1'b1;
    @(negedge clk_i);
    chk("h_boot_rd", 64'(icache_rd_o), 64'd1);
    chk("h_boot_pc", 64'(icache_pc_o), 64'h80000000);
    chk("h_boot_priv", 64'(icache_priv_o), 64'd3);
    chk("h_boot_valid", 64'(fetch_valid_o), 64'd0);

    // Reset with a request in flight: its late response must be ignored.
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; icache_accept_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = DB;
    @(negedge clk_i);
    chk("h_stale_valid", 64'(fetch_valid_o), 64'd0);
    chk("h_stale_rd", 64'(icache_rd_o), 64'd1);
    chk("h_stale_pc", 64'(icache_pc_o), 64'h80000000);
    @(posedge clk_i); #1;
    icache_accept_i = 1'b1; icache_valid_i = 1'b0;
    @(negedge clk_i);
    chk("h_hold_rd", 64'(icache_rd_o), 64'd1);
    chk("h_hold_pc", 64'(icache_pc_o), 64'h80000000);
    @(posedge clk_i); #1;
    icache_valid_i = 1'b1; icache_inst_i = DC;
    @(negedge clk_i);
    chk("h_boot_resp_valid", 64'(fetch_valid_o), 64'd1);
    chk("h_boot_resp_pc", 64'(fetch_pc_o), 64'h80000000);
    chk("h_boot_resp_instr", fetch_instr_o, DC);
    @(posedge clk_i); #1;
    icache_valid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
